// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned NREQ_MAX   = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    // Index width for n requesters; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin winner select: first valid requester after last_gnt, wrapping.
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest valid candidate is assigned last.
    always_comb begin
        gnt_idx = '0;
        cand    = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand = (IDX_W+1)'(last_gnt) + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (req_valid[cand[IDX_W-1:0]]) begin
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign any = |req_valid;
    assign gnt = any ? (NREQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Serialising arbiter for the single-port data memory; one transaction in flight.
// Build option DMEM_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy
);

    localparam int unsigned IDX_W = idx_w(NREQ);

    state_t            state;
    logic              we_q;
    logic [IDX_W-1:0]  win_q;
    logic [IDX_W-1:0]  last_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic [NREQ-1:0]   pick_gnt;
    logic              pick_any;
    logic              transfer;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .last_gnt  (last_gnt),
        .gnt       (pick_gnt),
        .gnt_idx   (pick_idx),
        .any       (pick_any)
    );

    assign sel_we    = req_we[pick_idx];
    assign sel_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[pick_idx*DATA_W +: DATA_W];

    // Accept is only offered while idle; reset masks it so all outputs drop at once.
    assign transfer  = (state == IDLE) && pick_any;
    assign req_ready = (transfer && !reset) ? pick_gnt : '0;
    assign busy      = (state != IDLE);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Rotation anchored after the top index makes requester 0 always first.
    assign last_gnt = IDX_W'(NREQ - 1);
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt <= IDX_W'(NREQ - 1);
        end else if (transfer) begin
            last_gnt <= pick_idx;
        end
    end
`endif

    // Transaction FSM; address/data stay latched through COMPLETE for the late write commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            win_q     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        we_q      <= sel_we;
                        win_q     <= pick_idx;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_read  <= ~sel_we;
                        mem_write <= sel_we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= COMPLETE;
                end
                COMPLETE: begin
                    if (!we_q) begin
                        rsp_rdata <= mem_rdata;
                        rsp_valid <= NREQ'(1) << win_q;
                    end
                    state <= IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
